// File: rtl/core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : core_fetch
// Purpose  : Instruction fetch sequencer for a simple in-order core. Issues a
//            request/grant/rvalid fetch at the current PC, presents the
//            fetched word to the execute stage for one cycle, then follows
//            the execute stage's next PC. Misaligned next PCs raise a sticky
//            trap that only reset clears.
// Ports    : clk, rst          - clock, synchronous active-high reset
//            halt              - suppress starting new fetches
//            nextpc            - next PC from execute (sampled in EXEC)
//            i_mem_req/addr    - fetch request and word address (addr == pc)
//            i_mem_gnt         - request accepted
//            i_mem_rvalid/rdata- response valid and instruction word
//            active, pc, ir    - instruction presented to execute stage
//            trap              - sticky misaligned-PC trap
//            instret           - retired-instruction count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module core_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic [31:0] nextpc,
    output logic        i_mem_req,
    output logic [31:0] i_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata,
    output logic        active,
    output logic [31:0] pc,
    output logic [31:0] ir,
    output logic        trap,
    output logic [31:0] instret
);

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        FETCH = 3'd0,
        WAIT  = 3'd1,
        EXEC  = 3'd2,
        IDLE  = 3'd3,
        TRAP  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_trap;
    logic [31:0] r_instret;

    logic        w_req;
    logic        w_active;
    logic        w_capture;
    logic        w_retire;
    logic        w_pc_load;
    logic        w_trap_set;

    // Next-state and control decode
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_active    = 1'b0;
        w_capture   = 1'b0;
        w_retire    = 1'b0;
        w_pc_load   = 1'b0;
        w_trap_set  = 1'b0;
        case (r_state)
            FETCH: begin
                // halt withdraws the request before it can be granted
                if (halt) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_req = 1'b1;
                    if (i_mem_gnt) begin
                        if (i_mem_rvalid) begin
                            w_capture   = 1'b1;
                            w_state_nxt = EXEC;
                        end else begin
                            w_state_nxt = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                // a granted fetch must complete; halt is not looked at here
                if (i_mem_rvalid) begin
                    w_capture   = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_active = 1'b1;
                w_retire = 1'b1;
                if (nextpc[1:0] == 2'b00) begin
                    w_pc_load   = 1'b1;
                    w_state_nxt = halt ? IDLE : FETCH;
                end else begin
                    w_trap_set  = 1'b1;
                    w_state_nxt = TRAP;
                end
            end
            IDLE: begin
                if (!halt) begin
                    w_state_nxt = FETCH;
                end
            end
            TRAP: begin
                w_state_nxt = TRAP;
            end
            default: begin
                w_state_nxt = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FETCH;
            r_pc      <= {RESET_PC[31:2], 2'b00};
            r_ir      <= c_NOP;
            r_trap    <= 1'b0;
            r_instret <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_ir <= i_mem_rdata;
            end
            if (w_pc_load) begin
                r_pc <= nextpc;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
            if (w_trap_set) begin
                r_trap <= 1'b1;
            end
        end
    end

    // While rst is held the state register may still show a pre-reset
    // state, so the handshake outputs are masked explicitly.
    assign i_mem_req  = w_req & ~rst;
    assign active     = w_active & ~rst;
    assign i_mem_addr = r_pc;
    assign pc         = r_pc;
    assign ir         = r_ir;
    assign trap       = r_trap;
    assign instret    = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_core_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_fetch
// Purpose  : Self-checking bench for core_fetch. A scripted memory responder
//            (configurable grant delay / response latency) drives the fetch
//            port; a transaction-level model predicts every output each cycle
//            and a few literal expectations pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt = 1'b0;
    logic [31:0] nextpc = 32'h0;
    logic        gnt = 1'b0;
    logic        rvalid = 1'b0;
    logic [31:0] rdata = 32'h0;

    wire         i_mem_req;
    wire  [31:0] i_mem_addr;
    wire         active;
    wire  [31:0] pc;
    wire  [31:0] ir;
    wire         trap;
    wire  [31:0] instret;

    always #5 clk = ~clk;

    core_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .halt         (halt),
        .nextpc       (nextpc),
        .i_mem_req    (i_mem_req),
        .i_mem_addr   (i_mem_addr),
        .i_mem_gnt    (gnt),
        .i_mem_rvalid (rvalid),
        .i_mem_rdata  (rdata),
        .active       (active),
        .pc           (pc),
        .ir           (ir),
        .trap         (trap),
        .instret      (instret)
    );

    int n_chk = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mdata(logic [31:0] a);
        return a ^ 32'h1357_0013;
    endfunction

    // ---------------- scenario controls (set by main sequence) -------------
    bit          c_rst = 1'b1;
    bit          c_halt = 1'b0;
    bit          c_npfix = 1'b0;
    bit          c_spur = 1'b0;
    logic [31:0] c_npval = 32'h0;
    int          c_gnt_delay = 0;
    int          c_rv_delay = 0;

    // ---------------- behavioural model ------------------------------------
    localparam int M_F = 0, M_W = 1, M_E = 2, M_I = 3, M_T = 4;
    int          m_mode = M_F;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_ir = 32'h13;
    logic        m_trap = 1'b0;
    logic [31:0] m_instret = 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_F; m_pc = 32'h0; m_ir = 32'h13; m_trap = 1'b0; m_instret = 32'h0;
        end else if (m_mode == M_F) begin
            if (halt) m_mode = M_I;
            else if (gnt && rvalid) begin m_ir = rdata; m_mode = M_E; end
            else if (gnt) m_mode = M_W;
        end else if (m_mode == M_W) begin
            if (rvalid) begin m_ir = rdata; m_mode = M_E; end
        end else if (m_mode == M_E) begin
            m_instret = m_instret + 32'd1;
            if (nextpc % 4 == 0) begin m_pc = nextpc; m_mode = halt ? M_I : M_F; end
            else begin m_trap = 1'b1; m_mode = M_T; end
        end else if (m_mode == M_I) begin
            if (!halt) m_mode = M_F;
        end
    end

    // ---------------- input driver and memory responder --------------------
    bit          pend = 1'b0;
    int          cnt = 0;
    int          wcnt = 0;
    logic [31:0] paddr = 32'h0;

    always @(negedge clk) begin
        rst    = c_rst;
        halt   = c_halt;
        nextpc = c_npfix ? c_npval : m_pc + 32'd4;
        gnt    = 1'b0;
        rvalid = 1'b0;
        #1;
        if (rst) begin
            pend = 1'b0;
            wcnt = 0;
        end else if (c_spur) begin
            rvalid = 1'b1;
            rdata  = 32'hDEAD_BEEF;
        end else if (pend) begin
            cnt--;
            if (cnt == 0) begin
                rvalid = 1'b1;
                rdata  = mdata(paddr);
                pend   = 1'b0;
            end
        end else if (i_mem_req) begin
            if (wcnt >= c_gnt_delay) begin
                gnt   = 1'b1;
                wcnt  = 0;
                paddr = i_mem_addr;
                if (c_rv_delay == 0) begin
                    rvalid = 1'b1;
                    rdata  = mdata(paddr);
                end else begin
                    pend = 1'b1;
                    cnt  = c_rv_delay;
                end
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
    end

    // ---------------- per-cycle compare ------------------------------------
    always @(negedge clk) begin
        #2;
        if (chk_on) begin
            chk("req",     i_mem_req,  (!rst && m_mode == M_F && !halt));
            chk("addr",    i_mem_addr, m_pc);
            chk("active",  active,     (!rst && m_mode == M_E));
            chk("pc",      pc,         m_pc);
            chk("ir",      ir,         m_ir);
            chk("trap",    trap,       m_trap);
            chk("instret", instret,    m_instret);
        end
    end

    // ---------------- main sequence ----------------------------------------
    task automatic cyc(int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_act(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!active && n < 40);
        if (!active) chk("act_timeout", active, 1);
    endtask

    int          n;
    logic [31:0] p;
    logic [31:0] ri;

    initial begin
        // reset values
        cyc(3);
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", ir, 32'h0000_0013);
        chk("rst_instret", instret, 32'h0);
        chk("rst_trap", trap, 0);
        chk("rst_active", active, 0);
        chk_on = 1'b1;

        // zero-wait memory: EXEC every second cycle at pc 0,4,8
        c_rst = 1'b0;
        wait_act(n); chk("zw_pc0", pc, 32'h0);
        wait_act(n); chk("zw_gap1", n, 2); chk("zw_pc4", pc, 32'h4);
        wait_act(n); chk("zw_gap2", n, 2); chk("zw_pc8", pc, 32'h8);
        cyc(1); chk("zw_instret3", instret, 32'd3);

        // delayed grant (2) and response 3 cycles after grant
        c_gnt_delay = 2; c_rv_delay = 3;
        wait_act(n); chk("slow_n", n, 6); chk("slow_ir", ir, mdata(32'hC));
        cyc(1); chk("slow_one_active", active, 0);

        // halt during EXEC, held 5 cycles
        c_gnt_delay = 0; c_rv_delay = 0;
        wait_act(n);
        c_halt = 1'b1; p = pc;
        cyc(1); chk("halt_pc", pc, p + 32'd4); chk("halt_noreq", i_mem_req, 0);
        cyc(4); c_halt = 1'b0;
        cyc(1); chk("resume_req", i_mem_req, 1); chk("resume_addr", i_mem_addr, p + 32'd4);

        // halt in FETCH before the grant
        c_gnt_delay = 3;
        cyc(1); c_halt = 1'b1;
        cyc(1); chk("fhalt_noreq", i_mem_req, 0);
        c_halt = 1'b0;
        wait_act(n);

        // halt ignored in WAIT; instret wrap from forced all-ones
        c_gnt_delay = 0; c_rv_delay = 3;
        cyc(2);
        c_halt = 1'b1;
        force dut.r_instret = 32'hFFFF_FFFF;
        m_instret = 32'hFFFF_FFFF;
        #1 release dut.r_instret;
        wait_act(n);
        cyc(1); chk("wrap_instret", instret, 32'h0);
        c_halt = 1'b0;

        // reset while in WAIT, then a spurious rvalid before the new grant
        wait_act(n);
        cyc(2);
        c_rst = 1'b1;
        cyc(1);
        c_rst = 1'b0; c_gnt_delay = 2; c_spur = 1'b1;
        cyc(1);
        c_spur = 1'b0;
        chk("spur_ir", ir, 32'h13); chk("spur_pc", pc, 32'h0); chk("spur_req", i_mem_req, 1);
        wait_act(n); chk("rst_fetch_ir", ir, mdata(32'h0));

        // misaligned next PC -> sticky trap
        c_gnt_delay = 0; c_rv_delay = 0;
        c_npfix = 1'b1; c_npval = 32'h0000_0102;
        p = pc; ri = instret;
        cyc(1);
        chk("trap_set", trap, 1); chk("trap_pc", pc, p); chk("trap_instret", instret, ri + 32'd1);
        cyc(5); chk("trap_noreq", i_mem_req, 0); chk("trap_sticky", trap, 1);

        // reset clears trap; 1-cycle memory gives 3 cycles per instruction
        c_rst = 1'b1;
        cyc(2); chk("trap_cleared", trap, 0);
        c_rst = 1'b0; c_npfix = 1'b0; c_rv_delay = 1;
        wait_act(n);
        wait_act(n); chk("lat1_n", n, 3); chk("lat1_pc", pc, 32'h4);

        cyc(2);
        chk_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
